// File: rtl/shift_mult_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier controller.
// SKIP_ZEROS=1 visits only the set multiplier bits; SKIP_ZEROS=0 visits all eight.
module shift_mult_ctrl #(
    parameter int SKIP_ZEROS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [2:0]  shift_amt
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on acceptance
    // RUN   | one multiplier bit processed per cycle
    // DONE  | one-cycle done pulse, product valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [2:0]  idx;

    logic [2:0]  low_idx;
    logic [2:0]  k;
    logic [15:0] addend;
    logic [15:0] acc_nxt;
    logic [7:0]  b_clr;
    logic        last;

    // lowest set bit of the remaining multiplier
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (b_reg[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    always_comb begin
        k       = (SKIP_ZEROS != 0) ? low_idx : idx;
        addend  = b_reg[k] ? ({8'b0, a_reg} << k) : 16'd0;
        acc_nxt = acc + addend;
        b_clr   = b_reg & ~(8'b1 << k);
        last    = (SKIP_ZEROS != 0) ? (b_clr == 8'd0) : (idx == 3'd7);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        shift_amt = 3'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ((SKIP_ZEROS != 0) && (b == 8'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                shift_amt = k;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= 8'd0;
            b_reg   <= 8'd0;
            acc     <= 16'd0;
            idx     <= 3'd0;
            product <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= 16'd0;
                        idx   <= 3'd0;
                        // zero multiplier skips RUN, so the result is loaded here
                        if (state_nxt == DONE) begin
                            product <= 16'd0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    idx <= idx + 3'd1;
                    if (SKIP_ZEROS != 0) begin
                        b_reg <= b_clr;
                    end
                    if (last) begin
                        product <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Directed bench for shift_mult_ctrl: one instance per SKIP_ZEROS setting.
module tb_shift_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        start0, start1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] product0, product1;
    logic [2:0]  shift0, shift1;
    logic        busy_m, done_m;
    logic [15:0] product_m;
    logic [2:0]  shift_m;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign start0    = start && !sel;
    assign start1    = start && sel;
    assign busy_m    = sel ? busy1 : busy0;
    assign done_m    = sel ? done1 : done0;
    assign product_m = sel ? product1 : product0;
    assign shift_m   = sel ? shift1 : shift0;

    shift_mult_ctrl #(.SKIP_ZEROS(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(product0), .shift_amt(shift0)
    );

    shift_mult_ctrl #(.SKIP_ZEROS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(product1), .shift_amt(shift1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v);
        int         n;
        bit         seen;
        bit         bad;
        logic [7:0] brem;
        logic [2:0] exp_sh;
        sel = v.sel;
        @(negedge clk);
        chk("idle_busy", busy_m, 1'b0);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        brem  = v.b;
        n     = 0;
        seen  = 0;
        bad   = 0;
        for (int c = 0; c < 20 && !seen && !bad; c++) begin
            if (done_m) begin
                seen = 1;
            end else if (busy_m) begin
                if (v.sel) begin
                    exp_sh = 3'd0;
                    for (int i = 7; i >= 0; i--) begin
                        if (brem[i]) exp_sh = 3'(i);
                    end
                    brem[exp_sh] = 1'b0;
                end else begin
                    exp_sh = 3'(n);
                end
                chk("run_shift_amt", shift_m, exp_sh);
                n++;
                @(negedge clk);
                a = 8'($urandom);
                b = 8'($urandom);
            end else begin
                chk("run_busy_or_done", 0, 1);
                bad = 1;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("run_cycles", n, v.cycles);
            chk("done_product", product_m, v.prod);
            chk("done_shift_zero", shift_m, 3'd0);
            chk("done_busy_low", busy_m, 1'b0);
            @(negedge clk);
            chk("done_one_cycle", done_m, 1'b0);
            chk("product_held", product_m, v.prod);
        end
    endtask

    int last_done;
    int pulses;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 8};
        vecs[1] = '{1'b1, 8'h5A, 8'h80, 16'h2D00, 1};
        vecs[2] = '{1'b1, 8'h12, 8'h00, 16'h0000, 0};
        vecs[3] = '{1'b0, 8'h12, 8'h00, 16'h0000, 8};
        vecs[4] = '{1'b1, 8'h03, 8'h15, 16'h003F, 3};
        vecs[5] = '{1'b1, 8'h00, 8'hFF, 16'h0000, 8};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01, 8};
        vecs[7] = '{1'b0, 8'h0D, 8'h0B, 16'h008F, 8};
        vecs[8] = '{1'b1, 8'hC8, 8'h64, 16'h4E20, 3};
        vecs[9] = '{1'b0, 8'h01, 8'h80, 16'h0080, 8};

        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_product0", product0, 16'd0);
        chk("rst_shift0", shift0, 3'd0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_product1", product1, 16'd0);
        chk("rst_shift1", shift1, 3'd0);

        // start accepted in the very first cycle with rst low
        sel   = 1'b1;
        rst   = 1'b0;
        start = 1'b1;
        a     = 8'd2;
        b     = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("first_start_busy", busy_m, 1'b1);
        chk("first_start_shift", shift_m, 3'd0);
        @(negedge clk);
        chk("first_start_done", done_m, 1'b1);
        chk("first_start_product", product_m, 16'd2);
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i]);

        // start pulsed during RUN is ignored
        sel = 1'b1;
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'h15;
        @(negedge clk);
        a = 8'd1; b = 8'd1;
        chk("ign_shift_0", shift_m, 3'd0);
        @(negedge clk);
        start = 1'b0;
        chk("ign_shift_2", shift_m, 3'd2);
        @(negedge clk);
        chk("ign_shift_4", shift_m, 3'd4);
        @(negedge clk);
        chk("ign_done", done_m, 1'b1);
        chk("ign_product", product_m, 16'd63);
        @(negedge clk);
        chk("ign_idle_busy", busy_m, 1'b0);
        chk("ign_idle_done", done_m, 1'b0);
        chk("ign_product_held", product_m, 16'd63);

        // reset in the third RUN cycle aborts the operation
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        chk("abort_run1", busy_m, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_run3_shift", shift_m, 3'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy_m, 1'b0);
        chk("abort_done", done_m, 1'b0);
        chk("abort_product", product_m, 16'd0);
        chk("abort_shift", shift_m, 3'd0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_m || busy_m) pulses++;
        end
        chk("abort_no_activity", pulses, 0);
        run_op('{1'b0, 8'd7, 8'd9, 16'd63, 8});

        // start held high: back-to-back operations
        sel = 1'b1;
        @(negedge clk);
        start = 1'b1; a = 8'd2; b = 8'd3;
        last_done = -1;
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (done_m) begin
                chk("b2b_product", product_m, 16'd6);
                if (last_done >= 0) chk("b2b_spacing", c - last_done, 4);
                last_done = c;
                pulses++;
            end
        end
        start = 1'b0;
        chk("b2b_pulses", pulses, 6);
        @(negedge clk);
        chk("b2b_stop_busy", busy_m, 1'b0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_mult_ctrl.md
SHIFT_MULT_CTRL -- requirements
Module: shift_mult_ctrl

Interface
REQ-001 The block SHALL have parameter SKIP_ZEROS, default 1, meaning 1 = iterate only over set multiplier bits and 0 = iterate over all 8 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 8 bits: unsigned multiplicand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, 8 bits: unsigned multiplier, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-009 The block SHALL have port product, output, 16 bits: result, valid from DONE and held until the next accepted start.
REQ-010 The block SHALL have port shift_amt, output, 3 bits: shift amount applied to the multiplicand in the current RUN cycle, 0 outside RUN.

Function
REQ-011 The block SHALL implement the states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture a_reg=a, b_reg=b, acc=0 and idx=0 at the clock edge.
REQ-013 After accepting start in IDLE, the block SHALL enter RUN, or enter DONE directly when SKIP_ZEROS=1 and b=0.
REQ-014 In RUN with SKIP_ZEROS=0, each cycle SHALL process bit idx: acc += ({8'b0,a_reg} << idx) when b_reg[idx]=1, then idx increments.
REQ-015 In RUN with SKIP_ZEROS=0, the block SHALL move to DONE after the cycle with idx=7, giving exactly 8 RUN cycles.
REQ-016 In RUN with SKIP_ZEROS=1, each cycle SHALL process k = the index of the lowest set bit of b_reg: acc += {8'b0,a_reg} << k, then clear b_reg[k].
REQ-017 In RUN with SKIP_ZEROS=1, the block SHALL move to DONE when b_reg becomes 0, giving popcount(b) RUN cycles.
REQ-018 The shifted operand and acc SHALL be 16 bits wide, with no truncation of the multiplicand shifted by 0..7.
REQ-019 The accumulator SHALL not overflow, since the maximum result is 255*255 = 65025.
REQ-020 shift_amt SHALL equal idx (SKIP_ZEROS=0) or k (SKIP_ZEROS=1) during RUN, and 0 in IDLE and DONE.
REQ-021 product SHALL be registered and SHALL be loaded with the final acc in the same edge that enters DONE.
REQ-022 The block SHALL stay in DONE for exactly one cycle and then return to IDLE unconditionally.
REQ-023 start SHALL be ignored in RUN and DONE, with no queuing; a_reg and b_reg SHALL not change outside acceptance.
REQ-024 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following DONE, giving a minimum spacing of 1 idle cycle.
REQ-025 a=0 SHALL follow the normal iteration (no early exit), and the result SHALL be 0.
REQ-026 Changes on a or b during RUN SHALL have no effect on the result.

Reset
REQ-027 With rst=1 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, product=0, shift_amt=0 and acc, a_reg, b_reg, idx all 0.
REQ-028 rst SHALL take priority over start and over every state transition, including mid-RUN.
REQ-029 An operation interrupted by reset SHALL produce no done pulse, and product SHALL read 0.
REQ-030 The first start SHALL be accepted in the first cycle with rst=0.

Verification
REQ-031 Bench: SKIP_ZEROS=0, a=255, b=255, start -> busy high 8 cycles, shift_amt 0..7, then done pulse, product=65025 (0xFE01).
REQ-032 Bench: SKIP_ZEROS=1, a=0x5A, b=0x80, start -> 1 RUN cycle with shift_amt=7, then done, product=0x2D00.
REQ-033 Bench: SKIP_ZEROS=1, b=0, start -> next cycle done=1 with no busy, product=0; SKIP_ZEROS=0, b=0 -> 8 RUN cycles, product=0.
REQ-034 Bench: SKIP_ZEROS=1, a=3, b=0x15, start -> shift_amt sequence 0,2,4, then done with product=63; pulse start again during RUN with a=1, b=1 -> ignored, product remains 63.
REQ-035 Bench: start a=200, b=100 and assert rst in the 3rd RUN cycle -> next cycle IDLE, all outputs 0, no done; then start a=7, b=9 -> product=63.
REQ-036 Bench: hold start=1 continuously with a=2, b=3 -> repeated ops each yielding product=6, done pulses separated by RUN length + 2 cycles.
